// File: rtl/npu_dma_arbiter.sv
// npu_dma_arbiter: shares one NPU DMA engine between scheduler PDMA (0),
// IB prefetcher (1) and host/debug (2); grant, issue, watchdog, done.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_req[2:0]          per-requester request
//   i_src/i_dst/i_len   packed descriptors, slice k = requester k
//   i_stop              block new grants
//   i_clr_timeout       clear sticky o_timeout
//   i_dma_finish        engine completion pulse
//   o_gnt/o_done        one-hot one-cycle pulses
//   o_dma_start         one-cycle engine start
//   o_dma_src/dst/len   latched descriptor
//   o_owner             current/last winner
//   o_idle, o_timeout   idle state, sticky watchdog abort
module npu_dma_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [2:0]          i_req,
  input  logic [3*ADDR_W-1:0] i_src,
  input  logic [3*ADDR_W-1:0] i_dst,
  input  logic [3*LEN_W-1:0]  i_len,
  input  logic                i_stop,
  input  logic                i_clr_timeout,
  input  logic                i_dma_finish,
  output logic [2:0]          o_gnt,
  output logic [2:0]          o_done,
  output logic                o_dma_start,
  output logic [ADDR_W-1:0]   o_dma_src,
  output logic [ADDR_W-1:0]   o_dma_dst,
  output logic [LEN_W-1:0]    o_dma_len,
  output logic [1:0]          o_owner,
  output logic                o_idle,
  output logic                o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYC - 1);
  localparam bit WD_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              to_q, to_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic [ADDR_W-1:0] src_a [3];
  logic [ADDR_W-1:0] dst_a [3];
  logic [LEN_W-1:0]  len_a [3];

  for (genvar k = 0; k < 3; k++) begin : g_slice
    assign src_a[k] = i_src[k*ADDR_W +: ADDR_W];
    assign dst_a[k] = i_dst[k*ADDR_W +: ADDR_W];
    assign len_a[k] = i_len[k*LEN_W +: LEN_W];
  end

  // Req 0 always wins; rr_q (1 or 2) breaks
  // a tie between req 1 and req 2.
  logic       pick1, pick2;
  logic [1:0] win;

  assign pick1 = !i_req[0] && i_req[1] &&
                 (!i_req[2] || (rr_q == 2'd1));
  assign pick2 = !i_req[0] && i_req[2] &&
                 (!i_req[1] || (rr_q == 2'd2));

  always_comb begin
    win = 2'd0;
    unique case (1'b1)
      i_req[0]: win = 2'd0;
      pick1:    win = 2'd1;
      pick2:    win = 2'd2;
      default:  win = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    to_d    = i_clr_timeout ? 1'b0 : to_q;
    unique case (state_q)
      S_IDLE: begin
        if (!i_stop && (|i_req)) begin
          owner_d = win;
          src_d   = src_a[win];
          dst_d   = dst_a[win];
          len_d   = len_a[win];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = i_dma_finish ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (i_dma_finish) begin
          state_d = S_DONE;
        end else if (WD_EN && (cnt_q == TO_LAST)) begin
          // abort wins over a clear in the same cycle
          state_d = S_DONE;
          to_d    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (owner_q == 2'd1) begin
          rr_d = 2'd2;
        end else if (owner_q == 2'd2) begin
          rr_d = 2'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      rr_q    <= 2'd1;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
    end
  end

  logic [2:0] owner_oh;

  assign owner_oh    = 3'b001 << owner_q;
  assign o_idle      = (state_q == S_IDLE);
  assign o_dma_start = (state_q == S_ISSUE);
  assign o_gnt       = o_dma_start ? owner_oh : 3'b000;
  assign o_done      = (state_q == S_DONE) ?
                       owner_oh : 3'b000;
  assign o_dma_src   = src_q;
  assign o_dma_dst   = dst_q;
  assign o_dma_len   = len_q;
  assign o_owner     = owner_q;
  assign o_timeout   = to_q;

endmodule

// File: tb/tb_npu_dma_arbiter.sv
// tb_npu_dma_arbiter: table-driven vectors plus
// hand sequences for watchdog and mid-transfer reset.
module tb_npu_dma_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  i_req;
  logic [95:0] i_src;
  logic [95:0] i_dst;
  logic [47:0] i_len;
  logic        i_stop;
  logic        i_clr;
  logic        i_fin;

  logic [2:0]  m_gnt, m_done, w_gnt, w_done;
  logic        m_start, m_idle, m_to;
  logic        w_start, w_idle, w_to;
  logic [31:0] m_src, m_dst, w_src, w_dst;
  logic [15:0] m_len, w_len;
  logic [1:0]  m_own, w_own;

  npu_dma_arbiter u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (i_req),
    .i_src         (i_src),
    .i_dst         (i_dst),
    .i_len         (i_len),
    .i_stop        (i_stop),
    .i_clr_timeout (i_clr),
    .i_dma_finish  (i_fin),
    .o_gnt         (m_gnt),
    .o_done        (m_done),
    .o_dma_start   (m_start),
    .o_dma_src     (m_src),
    .o_dma_dst     (m_dst),
    .o_dma_len     (m_len),
    .o_owner       (m_own),
    .o_idle        (m_idle),
    .o_timeout     (m_to)
  );

  npu_dma_arbiter #(.TIMEOUT_CYC(8)) u_wd (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (i_req),
    .i_src         (i_src),
    .i_dst         (i_dst),
    .i_len         (i_len),
    .i_stop        (i_stop),
    .i_clr_timeout (i_clr),
    .i_dma_finish  (i_fin),
    .o_gnt         (w_gnt),
    .o_done        (w_done),
    .o_dma_start   (w_start),
    .o_dma_src     (w_src),
    .o_dma_dst     (w_dst),
    .o_dma_len     (w_len),
    .o_owner       (w_own),
    .o_idle        (w_idle),
    .o_timeout     (w_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] src_c [3];
  logic [31:0] dst_c [3];
  logic [15:0] len_c [3];

  typedef struct {
    int         n;
    logic [2:0] req;
    logic       stop;
    logic       fin;
    logic [2:0] gnt;
    logic [2:0] done;
    logic       start;
    logic       idle;
    logic [1:0] own;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  task automatic add(input int n,
                     input logic [2:0] req,
                     input logic stop, fin,
                     input logic [2:0] gnt, done,
                     input logic start, idle,
                     input logic [1:0] own);
    tbl.push_back('{n, req, stop, fin, gnt,
                    done, start, idle, own});
  endtask

  // grant row, b busy rows, finish row, idle row
  task automatic xfer(input int b,
                      input logic [2:0] r0, r1,
                      input logic [1:0] k);
    logic [2:0] g;
    g = 3'b001 << k;
    add(1, r0, 0, 0, g, 0, 1, 0, k);
    add(b, r1, 0, 0, 0, 0, 0, 0, k);
    add(1, r1, 0, 1, 0, g, 0, 0, k);
    add(1, r1, 0, 0, 0, 0, 0, 1, k);
  endtask

  task automatic drive(input logic [2:0] r,
                       input logic s, f, c);
    i_req  = r;
    i_stop = s;
    i_fin  = f;
    i_clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string t);
    chk({t, " gnt"}, 64'(m_gnt), 64'(0));
    chk({t, " done"}, 64'(m_done), 64'(0));
    chk({t, " start"}, 64'(m_start), 64'(0));
    chk({t, " src"}, 64'(m_src), 64'(0));
    chk({t, " dst"}, 64'(m_dst), 64'(0));
    chk({t, " len"}, 64'(m_len), 64'(0));
    chk({t, " own"}, 64'(m_own), 64'(0));
    chk({t, " idle"}, 64'(m_idle), 64'(1));
    chk({t, " to"}, 64'(m_to), 64'(0));
  endtask

  task automatic chk_row(input int i,
                         input vec_t v);
    string t;
    t = $sformatf("row%0d", i);
    chk({t, " gnt"}, 64'(m_gnt), 64'(v.gnt));
    chk({t, " done"}, 64'(m_done), 64'(v.done));
    chk({t, " start"}, 64'(m_start),
        64'(v.start));
    chk({t, " idle"}, 64'(m_idle), 64'(v.idle));
    chk({t, " own"}, 64'(m_own), 64'(v.own));
    chk({t, " src"}, 64'(m_src),
        64'(src_c[v.own]));
    chk({t, " dst"}, 64'(m_dst),
        64'(dst_c[v.own]));
    chk({t, " len"}, 64'(m_len),
        64'(len_c[v.own]));
    chk({t, " to"}, 64'(m_to), 64'(0));
  endtask

  initial begin
    src_c[0] = 32'hA000_0000;
    src_c[1] = 32'h0000_1000;
    src_c[2] = 32'h0000_3000;
    dst_c[0] = 32'hB000_0000;
    dst_c[1] = 32'h0000_2000;
    dst_c[2] = 32'h0000_4000;
    len_c[0] = 16'd16;
    len_c[1] = 16'd64;
    len_c[2] = 16'd128;
    i_src = {src_c[2], src_c[1], src_c[0]};
    i_dst = {dst_c[2], dst_c[1], dst_c[0]};
    i_len = {len_c[2], len_c[1], len_c[0]};
    i_req  = 3'b000;
    i_stop = 1'b0;
    i_fin  = 1'b0;
    i_clr  = 1'b0;
    rst_n  = 1'b0;

    // single req 1, finish 10 cycles after start
    xfer(10, 3'b010, 3'b000, 2'd1);
    // stray finish in IDLE
    add(2, 3'b000, 0, 1, 0, 0, 0, 1, 2'd1);
    // finish in the ISSUE cycle
    xfer(0, 3'b001, 3'b000, 2'd0);
    // stop blocks a request seen in IDLE
    add(2, 3'b100, 1, 0, 0, 0, 0, 1, 2'd0);
    add(1, 3'b100, 0, 0, 3'b100, 0, 1, 0, 2'd2);
    // stop during BUSY with req 2 pending
    add(2, 3'b100, 1, 0, 0, 0, 0, 0, 2'd2);
    add(1, 3'b100, 1, 1, 0, 3'b100, 0, 0, 2'd2);
    add(3, 3'b100, 1, 0, 0, 0, 0, 1, 2'd2);
    xfer(0, 3'b100, 3'b000, 2'd2);
    // all held: req 0 wins, then RR 1,2,1,2
    xfer(3, 3'b111, 3'b111, 2'd0);
    xfer(3, 3'b111, 3'b111, 2'd0);
    xfer(3, 3'b110, 3'b110, 2'd1);
    xfer(3, 3'b110, 3'b110, 2'd2);
    xfer(3, 3'b110, 3'b110, 2'd1);
    xfer(3, 3'b110, 3'b110, 2'd2);

    repeat (2) @(posedge clk);
    #1;
    chk_rst("reset");
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        drive(tbl[i].req, tbl[i].stop,
              tbl[i].fin, 1'b0);
        chk_row(i, tbl[i]);
      end
    end

    // watchdog instance from a clean reset
    rst_n = 1'b0;
    drive(3'b000, 0, 0, 0);
    rst_n = 1'b1;
    drive(3'b010, 0, 0, 0);
    chk("wd gnt", 64'(w_gnt), 64'(3'b010));
    chk("wd start", 64'(w_start), 64'(1));
    // clear held high: abort must still set
    for (int i = 0; i < 8; i++) begin
      drive(3'b000, 0, 0, 1);
      chk($sformatf("wd busy%0d done", i),
          64'(w_done), 64'(0));
      chk($sformatf("wd busy%0d idle", i),
          64'(w_idle), 64'(0));
      chk($sformatf("wd busy%0d to", i),
          64'(w_to), 64'(0));
    end
    drive(3'b000, 0, 0, 1);
    chk("wd abort done", 64'(w_done),
        64'(3'b010));
    chk("wd abort to", 64'(w_to), 64'(1));
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 0, 0, 0);
      chk($sformatf("wd sticky%0d", i),
          64'(w_to), 64'(1));
      chk($sformatf("wd sticky%0d idle", i),
          64'(w_idle), 64'(1));
    end
    drive(3'b000, 0, 0, 1);
    chk("wd clr", 64'(w_to), 64'(0));
    chk("main no to", 64'(m_to), 64'(0));

    // main still busy on req 1: finish it,
    // moving the RR pointer to 2
    drive(3'b000, 0, 1, 0);
    chk("main done1", 64'(m_done), 64'(3'b010));
    drive(3'b000, 0, 0, 0);
    chk("main idle1", 64'(m_idle), 64'(1));
    drive(3'b001, 0, 0, 0);
    chk("main gnt0", 64'(m_gnt), 64'(3'b001));
    drive(3'b000, 0, 0, 0);
    drive(3'b000, 0, 0, 0);
    chk("main busy", 64'(m_idle), 64'(0));

    // reset mid-transfer, between clock edges
    rst_n = 1'b0;
    #2;
    chk_rst("async rst");
    i_fin = 1'b1;
    @(posedge clk);
    #1;
    chk("rst no done", 64'(m_done), 64'(0));
    i_fin = 1'b0;
    @(posedge clk);
    #1;
    chk("rst idle", 64'(m_idle), 64'(1));
    rst_n = 1'b1;
    // pointer back at 1: req 1 beats req 2
    drive(3'b110, 0, 0, 0);
    chk("rr after rst", 64'(m_gnt),
        64'(3'b010));
    chk("own after rst", 64'(m_own), 64'(1));
    drive(3'b000, 0, 0, 0);
    chk("post rst done", 64'(m_done), 64'(0));

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_dma_arbiter.md
# npu_dma_arbiter

Shares the single NPU DMA engine between three requesters: the instruction scheduler's PDMA execution (req 0), the instruction-buffer prefetcher (req 1) and the host/debug port (req 2). The block arbitrates, latches the winner's descriptor, issues one start pulse, tracks completion with a watchdog, and returns a per-requester done pulse. It sits between the NPU core control logic and the DMA engine's descriptor/start/finish interface.

## Interface
- ADDR_W, 32, source/destination address width
- LEN_W, 16, transfer length width (bytes)
- TIMEOUT_CYC, 4096, BUSY cycles before watchdog abort; 0 disables watchdog
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  3  request per requester, bit k = requester k
- i_src  in  3*ADDR_W  source addresses, slice k = requester k
- i_dst  in  3*ADDR_W  destination addresses, slice k
- i_len  in  3*LEN_W  lengths, slice k
- i_stop  in  1  block new grants; transfer in flight still completes
- i_clr_timeout  in  1  clears o_timeout
- i_dma_finish  in  1  DMA engine completion pulse
- o_gnt  out  3  one-cycle grant pulse, one-hot
- o_done  out  3  one-cycle completion pulse, one-hot
- o_dma_start  out  1  one-cycle start pulse to DMA engine
- o_dma_src / o_dma_dst  out  ADDR_W  latched descriptor
- o_dma_len  out  LEN_W  latched descriptor
- o_owner  out  2  index of current/last winner
- o_idle  out  1  high when state is IDLE
- o_timeout  out  1  sticky watchdog-abort flag

## Operation
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE: if !i_stop and any i_req, pick winner, register descriptor slice and owner, go ISSUE. Else stay.
- Arbitration: req 0 strict highest priority. Between req 1 and 2 round-robin: pointer starts at 1; after a req 1/2 transfer completes (DONE), pointer moves to the other one. Req 0 transfers do not move the pointer.
- ISSUE: o_dma_start=1, o_gnt[owner]=1; go BUSY; clear watchdog counter.
- BUSY: i_dma_finish → DONE. Else counter increments; when counter == TIMEOUT_CYC-1 (TIMEOUT_CYC≠0) → DONE with o_timeout set. i_stop has no effect here.
- DONE: o_done[owner]=1; update round-robin pointer; go IDLE.
- i_dma_finish is honoured in ISSUE (same as BUSY, → DONE) and ignored in IDLE/DONE.
- Requester holds i_req until its o_gnt; dropping i_req before grant withdraws it. i_req still high after o_done is a new request.
- Descriptor inputs are sampled only in the IDLE decision cycle; o_dma_src/dst/len and o_owner hold until next decision.
- o_timeout: set on watchdog abort, cleared by i_clr_timeout (set wins if same cycle).
- Watchdog counter width: clog2(TIMEOUT_CYC)+1, saturating.

## Timing
- Reset values: o_gnt=0, o_done=0, o_dma_start=0, o_dma_src/dst/len=0, o_owner=0, o_idle=1, o_timeout=0, RR pointer=1, state IDLE.
- All outputs registered or decoded from registered state; no combinational path from i_req to o_gnt.
- Request seen in IDLE at cycle N → o_gnt and o_dma_start high in cycle N+1.
- i_dma_finish at cycle M (ISSUE/BUSY) → o_done high at M+1, o_idle high at M+2; next grant earliest M+3.
- Minimum transfer turnaround 4 cycles (finish in ISSUE cycle).
- i_stop asserted in IDLE same cycle as req: no grant. Deasserting i_stop resumes arbitration next cycle.
- Reset mid-transfer: immediate return to reset values; no o_done for the aborted transfer.

## Test plan
- Single req 1, src=0x1000, dst=0x2000, len=64, finish 10 cycles after start → o_gnt[1] at N+1 with matching descriptor, o_done[1] one cycle after finish.
- All three req held continuously, finish 3 cycles after each start → grant order 0,0,0… while req0 held; drop req0 after first → order 1,2,1,2.
- TIMEOUT_CYC=8, no finish → o_done[owner] after 8 BUSY cycles, o_timeout=1 until i_clr_timeout.
- i_stop during BUSY with req 2 pending → current transfer completes with o_done, no further o_gnt, o_idle=1 held.
- i_dma_finish in ISSUE cycle → o_done next cycle; stray finish in IDLE → no output change.
- i_rst_n low during BUSY → all outputs reset values same cycle, no o_done, RR pointer=1.
